// File: rtl/axi_lite_mmio_regfile_if.sv
// AXI-lite bus between the PS master and the MMIO register file.
interface axi_lite_mmio_regfile_if #(
  parameter int ADDR_WIDTH = 26
);
  logic [ADDR_WIDTH-1:0] s_araddr;
  logic                  s_arvalid;
  logic                  s_arready;
  logic [31:0]           s_rdata;
  logic [1:0]            s_rresp;
  logic                  s_rvalid;
  logic                  s_rready;
  logic [ADDR_WIDTH-1:0] s_awaddr;
  logic                  s_awvalid;
  logic                  s_awready;
  logic [31:0]           s_wdata;
  logic [3:0]            s_wstrb;
  logic                  s_wvalid;
  logic                  s_wready;
  logic [1:0]            s_bresp;
  logic                  s_bvalid;
  logic                  s_bready;

  modport master (
    output s_araddr, s_arvalid, s_rready, s_awaddr, s_awvalid,
           s_wdata, s_wstrb, s_wvalid, s_bready,
    input  s_arready, s_rdata, s_rresp, s_rvalid, s_awready,
           s_wready, s_bresp, s_bvalid
  );

  modport slave (
    input  s_araddr, s_arvalid, s_rready, s_awaddr, s_awvalid,
           s_wdata, s_wstrb, s_wvalid, s_bready,
    output s_arready, s_rdata, s_rresp, s_rvalid, s_awready,
           s_wready, s_bresp, s_bvalid
  );
endinterface

// File: rtl/axi_lite_mmio_regfile.sv
// AXI-lite register file for the PS MMIO window: CTRL/STATUS/CYCLE plus
// scratch registers, with independent AW/W capture and SLVERR decode.
module axi_lite_mmio_regfile #(
    parameter int ADDR_WIDTH = 26,
    parameter int NUM_REGS   = 8,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    axi_lite_mmio_regfile_if.slave        s,
    input  logic [31:0]                   core_status,
    output logic                          core_rst,
    output logic [32*(NUM_REGS-3)-1:0]    user_regs
);
    localparam int IDX_W = ADDR_WIDTH - 2;
    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    // When the register count fills the whole index space every index decodes.
    localparam bit IDX_FULL = (64'(NUM_REGS) >= (64'd1 << IDX_W));

    typedef logic [IDX_W-1:0] idx_t;
    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
    } wbeat_t;

    function automatic logic in_range(input idx_t i);
        return IDX_FULL ? 1'b1 : (i < idx_t'(NUM_REGS));
    endfunction

    logic                          aw_held, w_held;
    idx_t                          aw_idx;
    wbeat_t                        w_beat;
    logic                          bvalid, rvalid;
    logic [1:0]                    bresp, rresp;
    logic [31:0]                   rdata, rd_val;
    logic                          rd_ok;
    logic [CNT_WIDTH-1:0]          cnt;
    logic [NUM_REGS-4:0][31:0]     scr;
    logic                          ctrl_rst;
    idx_t                          r_idx;
    logic                          aw_hs, w_hs, ar_hs, commit, w_ok, cnt_clr;
    logic                          unused_addr_lsbs;

    assign unused_addr_lsbs = ^{s.s_araddr[1:0], s.s_awaddr[1:0]};

    assign s.s_awready = !aw_held && !bvalid;
    assign s.s_wready  = !w_held && !bvalid;
    assign s.s_arready = !rvalid;
    assign s.s_bvalid  = bvalid;
    assign s.s_bresp   = bresp;
    assign s.s_rvalid  = rvalid;
    assign s.s_rdata   = rdata;
    assign s.s_rresp   = rresp;
    assign core_rst    = ctrl_rst;
    assign user_regs   = scr;

    assign aw_hs   = s.s_awvalid && s.s_awready;
    assign w_hs    = s.s_wvalid && s.s_wready;
    assign ar_hs   = s.s_arvalid && s.s_arready;
    assign commit  = aw_held && w_held;
    assign w_ok    = in_range(aw_idx);
    assign cnt_clr = commit && w_ok && (aw_idx == idx_t'(0)) &&
                     w_beat.strb[0] && w_beat.data[1];
    assign r_idx   = s.s_araddr[ADDR_WIDTH-1:2];

    always_comb begin
        rd_val = '0;
        rd_ok  = in_range(r_idx);
        if (rd_ok) begin
            if (r_idx == idx_t'(0))      rd_val = {31'b0, ctrl_rst};
            else if (r_idx == idx_t'(1)) rd_val = core_status;
            else if (r_idx == idx_t'(2)) rd_val = 32'(cnt);
            for (int i = 3; i < NUM_REGS; i++)
                if (r_idx == idx_t'(i)) rd_val = scr[i-3];
        end
    end

    // Write channel: AW and W park independently; the commit edge is the first
    // one that sees both held, so bvalid lands one edge after the later handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            aw_idx   <= '0;
            w_beat   <= '0;
            bvalid   <= 1'b0;
            bresp    <= RESP_OKAY;
            ctrl_rst <= 1'b1;
            scr      <= '0;
        end else begin
            if (aw_hs) begin
                aw_held <= 1'b1;
                aw_idx  <= s.s_awaddr[ADDR_WIDTH-1:2];
            end
            if (w_hs) begin
                w_held <= 1'b1;
                w_beat <= '{data: s.s_wdata, strb: s.s_wstrb};
            end
            if (commit) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                bvalid  <= 1'b1;
                bresp   <= w_ok ? RESP_OKAY : RESP_SLVERR;
                if (w_ok) begin
                    if (aw_idx == idx_t'(0) && w_beat.strb[0])
                        ctrl_rst <= w_beat.data[0];
                    for (int i = 3; i < NUM_REGS; i++)
                        if (aw_idx == idx_t'(i))
                            for (int b = 0; b < 4; b++)
                                if (w_beat.strb[b])
                                    scr[i-3][8*b +: 8] <= w_beat.data[8*b +: 8];
                end
            end else if (bvalid && s.s_bready) begin
                bvalid <= 1'b0;
            end
        end
    end

    // Read data is captured at the AR edge, so a same-edge write is not visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid <= 1'b0;
            rdata  <= '0;
            rresp  <= RESP_OKAY;
        end else if (ar_hs) begin
            rvalid <= 1'b1;
            rdata  <= rd_val;
            rresp  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
        end else if (rvalid && s.s_rready) begin
            rvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)            cnt <= '0;
        else if (cnt_clr)   cnt <= '0;
        else if (!ctrl_rst) cnt <= cnt + CNT_WIDTH'(1);
    end
endmodule

// File: tb/tb_axi_lite_mmio_regfile.sv
// Scoreboard bench for axi_lite_mmio_regfile: expected R/B results are queued
// as stimulus is issued and compared when the DUT responds.
module tb_axi_lite_mmio_regfile;
    localparam int AW = 26;
    localparam int NR = 8;
    localparam int UW = 32 * (NR - 3);

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   core_status;
    logic          core_rst;
    logic [UW-1:0] user_regs;
    logic [UW-1:0] exp_user;
    int            checks = 0;
    int            errors = 0;
    exp_t          rd_q[$];
    exp_t          wr_q[$];

    axi_lite_mmio_regfile_if #(.ADDR_WIDTH(AW)) bus ();

    axi_lite_mmio_regfile #(.ADDR_WIDTH(AW), .NUM_REGS(NR), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .s(bus), .core_status(core_status),
        .core_rst(core_rst), .user_regs(user_regs)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_read(input logic [AW-1:0] addr, output logic [31:0] d, output logic [1:0] r);
        int n = 0;
        bus.s_araddr = addr;
        bus.s_arvalid = 1'b1;
        while (!bus.s_arready && n < 50) begin tick(); n++; end
        tick();
        bus.s_arvalid = 1'b0;
        n = 0;
        while (!bus.s_rvalid && n < 50) begin tick(); n++; end
        checks++;
        if (!bus.s_rvalid) begin
            errors++;
            $display("FAIL rd_timeout addr=%h rvalid=%b required 1", addr, bus.s_rvalid);
        end
        d = bus.s_rdata;
        r = bus.s_rresp;
        bus.s_rready = 1'b1;
        tick();
        bus.s_rready = 1'b0;
    endtask

    task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] d, input logic [3:0] strb,
                             output logic [1:0] r);
        int n = 0;
        logic aw_hs, w_hs;
        bus.s_awaddr = addr; bus.s_awvalid = 1'b1;
        bus.s_wdata = d; bus.s_wstrb = strb; bus.s_wvalid = 1'b1;
        while ((bus.s_awvalid || bus.s_wvalid) && n < 50) begin
            aw_hs = bus.s_awvalid && bus.s_awready;
            w_hs  = bus.s_wvalid && bus.s_wready;
            tick();
            if (aw_hs) bus.s_awvalid = 1'b0;
            if (w_hs)  bus.s_wvalid = 1'b0;
            n++;
        end
        bus.s_awvalid = 1'b0;
        bus.s_wvalid = 1'b0;
        n = 0;
        while (!bus.s_bvalid && n < 50) begin tick(); n++; end
        checks++;
        if (!bus.s_bvalid) begin
            errors++;
            $display("FAIL wr_timeout addr=%h bvalid=%b required 1", addr, bus.s_bvalid);
        end
        r = bus.s_bresp;
        bus.s_bready = 1'b1;
        tick();
        bus.s_bready = 1'b0;
    endtask

    task automatic sb_read(input string name, input logic [AW-1:0] addr,
                           input logic [31:0] ed, input logic [1:0] er);
        logic [31:0] d;
        logic [1:0]  r;
        exp_t e;
        rd_q.push_back('{data: ed, resp: er});
        axi_read(addr, d, r);
        e = rd_q.pop_front();
        checks++;
        if (d !== e.data || r !== e.resp) begin
            errors++;
            $display("FAIL %s got data=%h resp=%b required data=%h resp=%b", name, d, r, e.data, e.resp);
        end
    endtask

    task automatic sb_write(input string name, input logic [AW-1:0] addr, input logic [31:0] d,
                            input logic [3:0] strb, input logic [1:0] er);
        logic [1:0] r;
        exp_t e;
        wr_q.push_back('{data: 32'h0, resp: er});
        axi_write(addr, d, strb, r);
        e = wr_q.pop_front();
        checks++;
        if (r !== e.resp) begin
            errors++;
            $display("FAIL %s got bresp=%b required %b", name, r, e.resp);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (core_rst !== 1'b1 || bus.s_rvalid !== 1'b0 || bus.s_bvalid !== 1'b0 ||
            bus.s_awready !== 1'b1 || bus.s_wready !== 1'b1 || bus.s_arready !== 1'b1 ||
            bus.s_rdata !== 32'h0 || bus.s_rresp !== 2'b00 || bus.s_bresp !== 2'b00 ||
            user_regs !== '0) begin
            errors++;
            $display("FAIL reset_state got core_rst=%b rv=%b bv=%b awr=%b wr=%b arr=%b rd=%h user=%h required 1/0/0/1/1/1/0/0",
                     core_rst, bus.s_rvalid, bus.s_bvalid, bus.s_awready, bus.s_wready,
                     bus.s_arready, bus.s_rdata, user_regs);
        end
        sb_read("reset_ctrl", 26'h0, 32'h1, 2'b00);
        sb_read("reset_cycle", 26'h8, 32'h0, 2'b00);
    endtask

    task automatic test_counter();
        logic [31:0] d;
        logic [1:0]  r;
        sb_write("ctrl_release", 26'h0, 32'h0, 4'h1, 2'b00);
        checks++;
        if (core_rst !== 1'b0) begin
            errors++;
            $display("FAIL core_rst_release got %b required 0", core_rst);
        end
        repeat (100) tick();
        // Increments start on the B-handshake edge: 1 + 100 edges before capture.
        sb_read("cycle_after_100", 26'h8, 32'd101, 2'b00);
        sb_write("cnt_clr", 26'h0, 32'h2, 4'h1, 2'b00);
        axi_read(26'h8, d, r);
        checks++;
        if (!(d < 32'd5) || r !== 2'b00) begin
            errors++;
            $display("FAIL cycle_after_clr got %0d resp=%b required <5 resp=00", d, r);
        end
        sb_read("ctrl_clr_reads0", 26'h0, 32'h0, 2'b00);
        core_status = 32'hCAFE_F00D;
        sb_write("status_ro_write", 26'h4, 32'h1234_5678, 4'hF, 2'b00);
        sb_read("status_live", 26'h4, 32'hCAFE_F00D, 2'b00);
    endtask

    task automatic test_w_before_aw();
        bus.s_wdata = 32'hA5A5_1234; bus.s_wstrb = 4'h3; bus.s_wvalid = 1'b1;
        tick();
        bus.s_wvalid = 1'b0;
        tick(); tick();
        bus.s_awaddr = 26'hC; bus.s_awvalid = 1'b1;
        tick();
        bus.s_awvalid = 1'b0;
        checks++;
        if (bus.s_bvalid !== 1'b0) begin
            errors++;
            $display("FAIL bvalid_early got %b required 0", bus.s_bvalid);
        end
        tick();
        exp_user[31:0] = 32'h0000_1234;
        checks++;
        if (bus.s_bvalid !== 1'b1 || bus.s_bresp !== 2'b00 || user_regs !== exp_user) begin
            errors++;
            $display("FAIL w_first_commit got bv=%b bresp=%b user=%h required 1/00/%h",
                     bus.s_bvalid, bus.s_bresp, user_regs, exp_user);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (bus.s_bvalid !== 1'b1 || bus.s_awready !== 1'b0 || bus.s_wready !== 1'b0) begin
                errors++;
                $display("FAIL b_stall[%0d] got bv=%b awr=%b wr=%b required 1/0/0",
                         i, bus.s_bvalid, bus.s_awready, bus.s_wready);
            end
        end
        bus.s_bready = 1'b1;
        tick();
        bus.s_bready = 1'b0;
        checks++;
        if (bus.s_bvalid !== 1'b0 || bus.s_awready !== 1'b1) begin
            errors++;
            $display("FAIL b_release got bv=%b awr=%b required 0/1", bus.s_bvalid, bus.s_awready);
        end
        sb_read("reg3_readback", 26'hC, 32'h0000_1234, 2'b00);
    endtask

    task automatic test_decode();
        sb_read("oob_read", 26'h20, 32'h0, 2'b10);
        sb_write("oob_write", 26'h20, 32'hDEAD_BEEF, 4'hF, 2'b10);
        sb_write("strb0_write", 26'h14, 32'hFFFF_FFFF, 4'h0, 2'b00);
        sb_write("reg7_bytes", 26'h1F, 32'h1122_3344, 4'hC, 2'b00);
        exp_user[4*32 +: 32] = 32'h1122_0000;
        checks++;
        if (user_regs !== exp_user) begin
            errors++;
            $display("FAIL decode_no_side_effect got %h required %h", user_regs, exp_user);
        end
    endtask

    task automatic test_collision();
        bus.s_awaddr = 26'h10; bus.s_awvalid = 1'b1;
        bus.s_wdata = 32'hFFFF_FFFF; bus.s_wstrb = 4'hF; bus.s_wvalid = 1'b1;
        tick();
        bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
        rd_q.push_back('{data: 32'h0, resp: 2'b00});
        bus.s_araddr = 26'h10; bus.s_arvalid = 1'b1;
        tick();
        bus.s_arvalid = 1'b0;
        begin
            exp_t e = rd_q.pop_front();
            checks++;
            if (bus.s_rvalid !== 1'b1 || bus.s_bvalid !== 1'b1 || bus.s_rdata !== e.data) begin
                errors++;
                $display("FAIL collision got rv=%b bv=%b rdata=%h required 1/1/%h",
                         bus.s_rvalid, bus.s_bvalid, bus.s_rdata, e.data);
            end
        end
        bus.s_rready = 1'b1; bus.s_bready = 1'b1;
        tick();
        bus.s_rready = 1'b0; bus.s_bready = 1'b0;
        exp_user[32 +: 32] = 32'hFFFF_FFFF;
        sb_read("collision_after", 26'h10, 32'hFFFF_FFFF, 2'b00);
    endtask

    task automatic test_reset_mid();
        bus.s_awaddr = 26'h14; bus.s_awvalid = 1'b1;
        bus.s_araddr = 26'hC; bus.s_arvalid = 1'b1;
        tick();
        bus.s_awvalid = 1'b0; bus.s_arvalid = 1'b0;
        checks++;
        if (bus.s_rvalid !== 1'b1 || bus.s_arready !== 1'b0) begin
            errors++;
            $display("FAIL r_pending got rv=%b arr=%b required 1/0", bus.s_rvalid, bus.s_arready);
        end
        rst = 1'b1;
        bus.s_wdata = 32'h55; bus.s_wstrb = 4'hF; bus.s_wvalid = 1'b1;
        tick();
        rst = 1'b0; bus.s_wvalid = 1'b0;
        exp_user = '0;
        checks++;
        if (bus.s_rvalid !== 1'b0 || bus.s_bvalid !== 1'b0 || core_rst !== 1'b1 || user_regs !== exp_user) begin
            errors++;
            $display("FAIL mid_reset got rv=%b bv=%b core_rst=%b user=%h required 0/0/1/0",
                     bus.s_rvalid, bus.s_bvalid, core_rst, user_regs);
        end
        bus.s_wdata = 32'h77; bus.s_wstrb = 4'hF; bus.s_wvalid = 1'b1;
        tick();
        bus.s_wvalid = 1'b0;
        tick();
        checks++;
        if (bus.s_bvalid !== 1'b0) begin
            errors++;
            $display("FAIL aw_dropped got bv=%b required 0", bus.s_bvalid);
        end
        bus.s_awaddr = 26'h14; bus.s_awvalid = 1'b1;
        tick();
        bus.s_awvalid = 1'b0;
        tick();
        exp_user[2*32 +: 32] = 32'h77;
        checks++;
        if (bus.s_bvalid !== 1'b1 || user_regs !== exp_user) begin
            errors++;
            $display("FAIL post_reset_write got bv=%b user=%h required 1/%h", bus.s_bvalid, user_regs, exp_user);
        end
        bus.s_bready = 1'b1;
        tick();
        bus.s_bready = 1'b0;
        sb_read("cycle_held", 26'h8, 32'h0, 2'b00);
    endtask

    task automatic test_back_to_back();
        sb_read("b2b_reg5", 26'h14, 32'h77, 2'b00);
        sb_read("b2b_reg0", 26'h0, 32'h1, 2'b00);
        sb_read("b2b_oob", 26'h3FF_FFFC, 32'h0, 2'b10);
    endtask

    initial begin
        core_status = 32'h0;
        exp_user = '0;
        bus.s_araddr = '0; bus.s_arvalid = 1'b0; bus.s_rready = 1'b0;
        bus.s_awaddr = '0; bus.s_awvalid = 1'b0;
        bus.s_wdata = '0; bus.s_wstrb = '0; bus.s_wvalid = 1'b0; bus.s_bready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        test_reset();
        test_counter();
        test_w_before_aw();
        test_decode();
        test_collision();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
